// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clocked-out frame,
// ACK check, bus release, with automatic resend on NACK or timeout.
module ps2_host_tx #(
  parameter int CLK_PER_US  = 50,
  parameter int INHIBIT_US  = 120,
  parameter int START_TO_US = 15000,
  parameter int FRAME_TO_US = 2000,
  parameter int MAX_RETRY   = 2
) (
  input  logic       qzt_clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       send,
  inout  wire        PS2C,
  inout  wire        PS2D,
  output logic       busy,
  output logic       done,
  output logic       nack_err,
  output logic       tmo_err,
  output logic [2:0] retries,
  output logic [3:0] status
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    REQ     = 3'd2,
    DATA    = 3'd3,
    ACK     = 3'd4,
    RELEASE = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam int PRE_W      = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int US_W       = 20;
  localparam int RELEASE_US = 20;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  state_t            state;
  logic              c_meta, c_sync, c_last;
  logic              d_meta, d_sync;
  logic              send_last;
  logic              c_fall, send_rise, us_tick, frame_exp;
  logic              fail_nack, fail_tmo;
  logic [PRE_W-1:0]  pre_cnt;
  logic [US_W-1:0]   us_cnt;
  logic [US_W-1:0]   frame_cnt;
  logic              c_low, d_low;
  logic [7:0]        byte_lat;
  logic [3:0]        bit_idx;
  logic [9:0]        frame_bits;

  assign PS2C = c_low ? 1'b0 : 1'bz;
  assign PS2D = d_low ? 1'b0 : 1'bz;

  assign status     = {1'b0, state};
  assign c_fall     = c_last & ~c_sync;
  assign send_rise  = send & ~send_last;
  assign us_tick    = (pre_cnt == PRE_W'(CLK_PER_US - 1));
  assign frame_exp  = (frame_cnt >= US_W'(FRAME_TO_US));
  assign frame_bits = {1'b1, odd_parity(byte_lat), byte_lat};

  // Line synchronisers; send_last starts high so a send held through reset is not an edge
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      c_meta    <= 1'b1;
      c_sync    <= 1'b1;
      c_last    <= 1'b1;
      d_meta    <= 1'b1;
      d_sync    <= 1'b1;
      send_last <= 1'b1;
    end else begin
      c_meta    <= PS2C;
      c_sync    <= c_meta;
      c_last    <= c_sync;
      d_meta    <= PS2D;
      d_sync    <= d_meta;
      send_last <= send;
    end
  end

  always_ff @(posedge qzt_clk) begin
    if (state == IDLE && send_rise) byte_lat <= data;
  end

  always_comb begin
    fail_nack = 1'b0;
    fail_tmo  = 1'b0;
    case (state)
      REQ:     fail_tmo = !c_fall && (us_cnt >= US_W'(START_TO_US));
      DATA:    fail_tmo = frame_exp;
      ACK: begin
        fail_tmo  = frame_exp;
        fail_nack = !frame_exp && c_fall && d_sync;
      end
      RELEASE: fail_tmo = frame_exp;
      default: ;
    endcase
  end

  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      c_low     <= 1'b0;
      d_low     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack_err  <= 1'b0;
      tmo_err   <= 1'b0;
      retries   <= '0;
      bit_idx   <= '0;
      pre_cnt   <= '0;
      us_cnt    <= '0;
      frame_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (us_tick) begin
        pre_cnt <= '0;
        us_cnt  <= us_cnt + 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
      if (us_tick && (state == DATA || state == ACK || state == RELEASE))
        frame_cnt <= frame_cnt + 1'b1;

      if (fail_nack || fail_tmo) begin
        pre_cnt <= '0;
        us_cnt  <= '0;
        d_low   <= 1'b0;
        if (retries < 3'(MAX_RETRY)) begin
          retries <= retries + 1'b1;
          c_low   <= 1'b1;
          state   <= INHIBIT;
        end else begin
          c_low    <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
          nack_err <= fail_nack;
          tmo_err  <= fail_tmo;
          state    <= DONE;
        end
      end else begin
        case (state)
          IDLE: begin
            c_low <= 1'b0;
            d_low <= 1'b0;
            if (send_rise) begin
              retries  <= '0;
              nack_err <= 1'b0;
              tmo_err  <= 1'b0;
              busy     <= 1'b1;
              c_low    <= 1'b1;
              pre_cnt  <= '0;
              us_cnt   <= '0;
              state    <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (us_cnt == US_W'(INHIBIT_US)) d_low <= 1'b1;
            if (us_cnt == US_W'(INHIBIT_US + 1)) begin
              c_low   <= 1'b0;
              pre_cnt <= '0;
              us_cnt  <= '0;
              state   <= REQ;
            end
          end
          REQ: begin
            if (c_fall) begin
              d_low     <= ~frame_bits[0];
              bit_idx   <= 4'd1;
              frame_cnt <= '0;
              pre_cnt   <= '0;
              us_cnt    <= '0;
              state     <= DATA;
            end
          end
          // D1..D7, parity, then stop (released line) on successive falling edges
          DATA: begin
            if (c_fall) begin
              d_low   <= ~frame_bits[bit_idx];
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == 4'd9) begin
                pre_cnt <= '0;
                us_cnt  <= '0;
                state   <= ACK;
              end
            end
          end
          ACK: begin
            if (c_fall) begin
              pre_cnt <= '0;
              us_cnt  <= '0;
              state   <= RELEASE;
            end
          end
          RELEASE: begin
            if (!(c_sync && d_sync)) begin
              pre_cnt <= '0;
              us_cnt  <= '0;
            end else if (us_cnt >= US_W'(RELEASE_US)) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              pre_cnt <= '0;
              us_cnt  <= '0;
              state   <= DONE;
            end
          end
          DONE: begin
            pre_cnt <= '0;
            us_cnt  <= '0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter CLK_PER_US, default 50: qzt_clk cycles per microsecond; 1 us tick prescaler terminal count.
REQ-002 SHALL have parameter INHIBIT_US, default 120: duration PS2C is held low before the request-to-send.
REQ-003 SHALL have parameter START_TO_US, default 15000: maximum wait from request-to-send to first device falling edge.
REQ-004 SHALL have parameter FRAME_TO_US, default 2000: maximum duration from first falling edge to ACK.
REQ-005 SHALL have parameter MAX_RETRY, default 2: automatic resends after NACK/timeout (0..7).
REQ-006 SHALL have port qzt_clk  in  1  system clock; all logic on rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port data  in  8  byte to send; start, parity and stop generated internally.
REQ-009 SHALL have port send  in  1  rising edge starts a transfer when idle.
REQ-010 SHALL have port PS2C  inout  1  PS/2 clock, open-drain (drive 0 or z only).
REQ-011 SHALL have port PS2D  inout  1  PS/2 data, open-drain (drive 0 or z only).
REQ-012 SHALL have port busy  out  1  high from accepted send until done.
REQ-013 SHALL have port done  out  1  one-cycle pulse at end of transfer (success or failure).
REQ-014 SHALL have port nack_err  out  1  valid with done: last attempt ended in NACK.
REQ-015 SHALL have port tmo_err  out  1  valid with done: last attempt ended in timeout.
REQ-016 SHALL have port retries  out  3  attempts repeated in the current/last transfer.
REQ-017 SHALL have port status  out  4  current state code, for inspection.

Function
REQ-018 SHALL synchronise PS2C/PS2D through 2 flip-flops; edge detection SHALL use synchronised values only.
REQ-019 SHALL derive a 1-cycle us_tick every CLK_PER_US cycles; one shared us counter SHALL be cleared on every state entry.
REQ-020 SHALL latch data on accepted send and form the frame: D0..D7 LSB first, odd parity P (ones in D plus P odd), stop 1.
REQ-021 SHALL use states IDLE=0, INHIBIT=1, REQ=2, DATA=3, ACK=4, RELEASE=5, DONE=6.
REQ-022 IDLE: both lines z; send rising edge -> INHIBIT, PS2C driven 0, retries=0, busy=1; send ignored in every other state.
REQ-023 INHIBIT: after INHIBIT_US ticks drive PS2D 0, one us later release PS2C -> REQ.
REQ-024 REQ: first synchronised PS2C falling edge -> DATA, put D0 on PS2D; START_TO_US elapsed -> timeout.
REQ-025 DATA: each subsequent falling edge SHALL present next bit (D1..D7, P, stop=z); after the stop bit is presented -> ACK.
REQ-026 ACK: next falling edge samples PS2D; 0 = ACK -> RELEASE, 1 = NACK.
REQ-027 FRAME_TO_US, counted from entry to DATA, elapsed before ACK sampled -> timeout.
REQ-028 NACK or timeout: release both lines; if retries<MAX_RETRY increment retries and re-enter INHIBIT, else DONE with the matching error flag set.
REQ-029 RELEASE: wait until PS2C and PS2D both synchronised high for 20 consecutive us -> DONE; subject to the frame timeout.
REQ-030 DONE: one-cycle done pulse, busy=0, -> IDLE; error flags and retries SHALL hold until next accepted send.
REQ-031 A send edge coincident with done SHALL be ignored.
REQ-032 Host SHALL change PS2D only within 2 cycles after a synchronised falling edge.

Reset
REQ-033 Reset asserted SHALL immediately release PS2C/PS2D to z, force IDLE, busy=0, done=0, nack_err=0, tmo_err=0, retries=0, status=0, including mid-frame.
REQ-034 After reset deassertion the send edge detector SHALL treat send as previously low only if send is low at the first clock.

Verification
REQ-035 data=0xF4, device model clocks 80 us period, ACKs -> PS2D bits 0,0,1,0,1,1,1,1, P=0, stop z; done with no error flags, retries=0.
REQ-036 data=0x00, device NACKs twice then ACKs -> retries=2, P=1 each frame, done once with nack_err=0.
REQ-037 MAX_RETRY=2, device always NACKs -> 3 frames observed, done with nack_err=1, retries=2.
REQ-038 Device never clocks -> PS2C low INHIBIT_US per attempt, done after 3×(INHIBIT+START_TO_US) ≈ 45.4 ms with tmo_err=1.
REQ-039 Reset asserted after 4th falling edge -> both lines z within same cycle, status=0; a new send then completes normally.
REQ-040 send pulsed while busy -> ignored; exactly one done pulse emitted.
